// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for the two-port work-RAM arbiter.
interface ram_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 14
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MASK_W = 2;

  // Port A (CPU bus)
  logic                     a_req;
  logic                     a_we;
  logic [MASK_W-1:0]        a_mask;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_W-1:0]        a_din;
  logic [DATA_W-1:0]        a_dout;
  logic                     a_ack;

  // Port B (secondary master)
  logic                     b_req;
  logic                     b_we;
  logic [MASK_W-1:0]        b_mask;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_W-1:0]        b_din;
  logic [DATA_W-1:0]        b_dout;
  logic                     b_ack;

  // Shared single-port RAM
  logic                     ram_we;
  logic [MASK_W-1:0]        ram_mask;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_W-1:0]        ram_din;
  logic [DATA_W-1:0]        ram_dout;

  // Arbiter view
  modport slave (
    input  a_req, a_we, a_mask, a_addr, a_din,
    input  b_req, b_we, b_mask, b_addr, b_din,
    input  ram_dout,
    output a_dout, a_ack, b_dout, b_ack,
    output ram_we, ram_mask, ram_addr, ram_din
  );

  // Environment view: requesters plus the RAM instance
  modport master (
    output a_req, a_we, a_mask, a_addr, a_din,
    output b_req, b_we, b_mask, b_addr, b_din,
    output ram_dout,
    input  a_dout, a_ack, b_dout, b_ack,
    input  ram_we, ram_mask, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-masked, synchronous-read RAM between
// two req/ack requesters. One access takes four cycles: IDLE (grant),
// ACCESS (RAM samples), READ (data returns), ACK (completion pulse).
module ram_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 14
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MASK_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     last_b_q, last_b_d;   // 1: B granted most recently
  logic                     gnt_b_q, gnt_b_d;     // 1: current access belongs to B
  logic                     wr_q, wr_d;           // current access is a write
  logic                     ram_we_q, ram_we_d;
  logic [MASK_W-1:0]        ram_mask_q, ram_mask_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_din_q, ram_din_d;
  logic                     a_ack_q, a_ack_d;
  logic                     b_ack_q, b_ack_d;
  logic [DATA_W-1:0]        a_dout_q, a_dout_d;
  logic [DATA_W-1:0]        b_dout_q, b_dout_d;
  logic                     pick_b;

  // Next-state and next-register values; everything holds unless a state acts on it
  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    gnt_b_d    = gnt_b_q;
    wr_d       = wr_q;
    ram_we_d   = ram_we_q;
    ram_mask_d = ram_mask_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    a_ack_d    = a_ack_q;
    b_ack_d    = b_ack_q;
    a_dout_d   = a_dout_q;
    b_dout_d   = b_dout_q;
    // B wins when alone, or on a tie when A was served last
    pick_b     = bus.b_req && (!bus.a_req || !last_b_q);

    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          gnt_b_d    = pick_b;
          last_b_d   = pick_b;
          wr_d       = pick_b ? bus.b_we   : bus.a_we;
          ram_we_d   = pick_b ? bus.b_we   : bus.a_we;
          ram_mask_d = pick_b ? bus.b_mask : bus.a_mask;
          ram_addr_d = pick_b ? bus.b_addr : bus.a_addr;
          ram_din_d  = pick_b ? bus.b_din  : bus.a_din;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        ram_we_d = 1'b0;
        state_d  = READ;
      end
      READ: begin
        // Write cycles return pre-write data, so dout only loads on reads
        if (gnt_b_q) begin
          b_ack_d = 1'b1;
          if (!wr_q) b_dout_d = bus.ram_dout;
        end else begin
          a_ack_d = 1'b1;
          if (!wr_q) a_dout_d = bus.ram_dout;
        end
        state_d = ACK;
      end
      ACK: begin
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      gnt_b_q    <= 1'b0;
      wr_q       <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_mask_q <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_dout_q   <= '0;
      b_dout_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      gnt_b_q    <= gnt_b_d;
      wr_q       <= wr_d;
      ram_we_q   <= ram_we_d;
      ram_mask_q <= ram_mask_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
    end
  end

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_mask = ram_mask_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_dout   = a_dout_q;
  assign bus.b_dout   = b_dout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM instance, transaction-timing reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_ram_arbiter;
  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();
  ram_arbiter #(.ADDRESS_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Work RAM: byte-masked write, registered read returning pre-write data
  logic [15:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      if (bus.ram_mask[0]) mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
      if (bus.ram_mask[1]) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
    end
    bus.ram_dout <= mem[bus.ram_addr];
  end

  // Reference model: an access granted at the end of cycle s has ram_we in
  // s+1, ack/dout in s+3, and the arbiter accepts again at the end of s+4.
  logic [15:0] shadow [0:DEPTH-1];
  int          m_cyc, m_s;
  bit          m_busy, m_last_b, m_port, m_we;
  logic [1:0]  m_mask;
  logic [13:0] m_addr;
  logic [15:0] m_din, m_adout, m_bdout;
  int          tb_cyc = 0;

  always @(posedge clk) tb_cyc++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_s = 0; m_busy = 0; m_last_b = 1; m_port = 0; m_we = 0;
      m_mask = '0; m_addr = '0; m_din = '0; m_adout = '0; m_bdout = '0;
    end else begin
      if (m_busy && m_cyc == m_s + 1 && m_we) begin
        if (m_mask[0]) shadow[m_addr][7:0]  = m_din[7:0];
        if (m_mask[1]) shadow[m_addr][15:8] = m_din[15:8];
      end
      if (m_busy && m_cyc == m_s + 2 && !m_we) begin
        if (m_port) m_bdout = shadow[m_addr];
        else        m_adout = shadow[m_addr];
      end
      if (!m_busy && (bus.a_req || bus.b_req)) begin
        m_port   = (bus.a_req && bus.b_req) ? !m_last_b : bus.b_req;
        m_last_b = m_port;
        m_we     = m_port ? bus.b_we   : bus.a_we;
        m_mask   = m_port ? bus.b_mask : bus.a_mask;
        m_addr   = m_port ? bus.b_addr : bus.a_addr;
        m_din    = m_port ? bus.b_din  : bus.a_din;
        m_s      = m_cyc;
        m_busy   = 1;
      end else if (m_busy && m_cyc == m_s + 3) begin
        m_busy = 0;
      end
      m_cyc++;
    end
  end

  // Per-cycle compare of every DUT output against the model
  bit started = 0;
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("ram_we",   32'(bus.ram_we),   32'(m_busy && m_cyc == m_s + 1 && m_we));
      chk("ram_mask", 32'(bus.ram_mask), 32'(m_mask));
      chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
      chk("ram_din",  32'(bus.ram_din),  32'(m_din));
      chk("a_ack",    32'(bus.a_ack),    32'(m_busy && m_cyc == m_s + 3 && !m_port));
      chk("b_ack",    32'(bus.b_ack),    32'(m_busy && m_cyc == m_s + 3 && m_port));
      chk("a_dout",   32'(bus.a_dout),   32'(m_adout));
      chk("b_dout",   32'(bus.b_dout),   32'(m_bdout));
    end
  end

  // Event counters for directed checks
  int we_cnt = 0;
  int ev_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_we) we_cnt++;
      if (bus.ram_we || bus.a_ack || bus.b_ack) ev_cnt++;
    end
  end

  task automatic access(input bit port, input bit we, input logic [1:0] mask, input int addr,
                        input logic [15:0] din, output logic [15:0] dout, output int lat);
    bit got = 0;
    dout = '0;
    lat  = 0;
    @(negedge clk);
    if (!port) begin
      bus.a_req = 1; bus.a_we = we; bus.a_mask = mask; bus.a_addr = AW'(addr); bus.a_din = din;
    end else begin
      bus.b_req = 1; bus.b_we = we; bus.b_mask = mask; bus.b_addr = AW'(addr); bus.b_din = din;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (port ? bus.b_ack : bus.a_ack) begin
        got  = 1;
        dout = port ? bus.b_dout : bus.a_dout;
      end
    end
    bus.a_req = 0;
    bus.b_req = 0;
    if (!got) chk("access_timeout", 32'(got), 32'(1));
  endtask

  logic [15:0] d;
  int          lat, w0, e0, idx, prev, aseen;
  bit          ack_port [$];
  int          ack_cyc  [$];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    bus.a_req = 0; bus.a_we = 0; bus.a_mask = '0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_mask = '0; bus.b_addr = '0; bus.b_din = '0;
    reset = 1;
    repeat (3) @(negedge clk);
    reset   = 0;
    started = 1;
    repeat (2) @(negedge clk);

    // Full-word write then read back, with latency and ram_we pulse count
    w0 = we_cnt;
    access(0, 1, 2'b11, 5, 16'h1234, d, lat);
    chk("wr_latency", 32'(lat), 32'(3));
    chk("wr_we_cycles", 32'(we_cnt - w0), 32'(1));
    w0 = we_cnt;
    access(0, 0, 2'b11, 5, 16'h0000, d, lat);
    chk("rd_0x1234", 32'(d), 32'h1234);
    chk("rd_latency", 32'(lat), 32'(3));
    chk("rd_no_we", 32'(we_cnt - w0), 32'(0));

    // Byte masks, including an empty mask that is still acknowledged
    access(0, 1, 2'b01, 5, 16'hABCD, d, lat);
    access(0, 0, 2'b11, 5, 16'h0000, d, lat);
    chk("mask01", 32'(d), 32'h12CD);
    access(0, 1, 2'b10, 5, 16'hABCD, d, lat);
    access(0, 0, 2'b11, 5, 16'h0000, d, lat);
    chk("mask10", 32'(d), 32'hABCD);
    access(0, 1, 2'b00, 5, 16'h5555, d, lat);
    chk("mask00_acked", 32'(lat), 32'(3));
    access(0, 0, 2'b11, 5, 16'h0000, d, lat);
    chk("mask00_data", 32'(d), 32'hABCD);

    // Asynchronous reset between clock edges clears all outputs at once
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_ram_we",   32'(bus.ram_we),   32'(0));
    chk("arst_ram_mask", 32'(bus.ram_mask), 32'(0));
    chk("arst_ram_addr", 32'(bus.ram_addr), 32'(0));
    chk("arst_ram_din",  32'(bus.ram_din),  32'(0));
    chk("arst_a_ack",    32'(bus.a_ack),    32'(0));
    chk("arst_b_ack",    32'(bus.b_ack),    32'(0));
    chk("arst_a_dout",   32'(bus.a_dout),   32'(0));
    chk("arst_b_dout",   32'(bus.b_dout),   32'(0));
    @(negedge clk);
    reset = 0;
    e0 = ev_cnt;
    repeat (10) @(negedge clk);
    chk("idle_no_events", 32'(ev_cnt - e0), 32'(0));

    // Port B alone, back-to-back reads of 0..3 with req held high
    for (int i = 0; i < 4; i++) access(0, 1, 2'b11, i, 16'h1000 + 16'(i), d, lat);
    @(negedge clk);
    bus.b_req = 1; bus.b_we = 0; bus.b_mask = 2'b11; bus.b_addr = '0;
    idx = 0; prev = 0; aseen = 0;
    for (int t = 0; t < 40 && idx < 4; t++) begin
      @(negedge clk);
      if (bus.a_ack) aseen++;
      if (bus.b_ack) begin
        chk("b_seq_data", 32'(bus.b_dout), 32'(16'h1000 + 16'(idx)));
        if (idx > 0) chk("b_seq_gap", 32'(tb_cyc - prev), 32'(4));
        prev = tb_cyc;
        idx++;
        bus.b_addr = AW'(idx);
      end
    end
    bus.b_req = 0;
    chk("b_seq_count", 32'(idx), 32'(4));
    chk("b_seq_no_a_ack", 32'(aseen), 32'(0));
    repeat (6) @(negedge clk);

    // Contention from the first cycle after reset: A, B, A, B, 4 cycles apart
    reset = 1;
    @(negedge clk);
    reset = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_mask = 2'b11; bus.a_addr = AW'(0);
    bus.b_req = 1; bus.b_we = 0; bus.b_mask = 2'b11; bus.b_addr = AW'(1);
    for (int t = 0; t < 40 && ack_port.size() < 4; t++) begin
      @(negedge clk);
      if (bus.a_ack) begin
        ack_port.push_back(0); ack_cyc.push_back(tb_cyc);
        chk("cont_a_data", 32'(bus.a_dout), 32'h1000);
      end
      if (bus.b_ack) begin
        ack_port.push_back(1); ack_cyc.push_back(tb_cyc);
        chk("cont_b_data", 32'(bus.b_dout), 32'h1001);
      end
    end
    bus.a_req = 0; bus.b_req = 0;
    chk("cont_count", 32'(ack_port.size()), 32'(4));
    for (int k = 0; k < ack_port.size(); k++) begin
      chk("cont_order", 32'(ack_port[k]), 32'(k % 2));
      if (k > 0) chk("cont_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'(4));
    end
    repeat (6) @(negedge clk);

    // Reset during the ACCESS cycle of a write aborts it
    bus.a_req = 1; bus.a_we = 1; bus.a_mask = 2'b11; bus.a_addr = AW'(7); bus.a_din = 16'hFFFF;
    @(negedge clk);
    chk("abort_we_before", 32'(bus.ram_we), 32'(1));
    bus.a_req = 0;
    #2 reset = 1;
    #1;
    chk("abort_we_dropped", 32'(bus.ram_we), 32'(0));
    chk("abort_no_ack", 32'(bus.a_ack), 32'(0));
    @(negedge clk);
    reset = 0;
    e0 = ev_cnt;
    repeat (5) @(negedge clk);
    chk("abort_quiet", 32'(ev_cnt - e0), 32'(0));
    access(0, 0, 2'b11, 7, 16'h0000, d, lat);
    chk("abort_addr7", 32'(d), 32'h0000);

    // Randomized requests on both ports, checked cycle by cycle by the model
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      bus.a_req  = ($urandom % 4) != 0;
      bus.a_we   = 1'($urandom % 2);
      bus.a_mask = 2'($urandom % 4);
      bus.a_addr = AW'($urandom_range(0, 15));
      bus.a_din  = 16'($urandom);
      bus.b_req  = ($urandom % 3) != 0;
      bus.b_we   = 1'($urandom % 2);
      bus.b_mask = 2'($urandom % 4);
      bus.b_addr = AW'($urandom_range(0, 15));
      bus.b_din  = 16'($urandom);
    end
    bus.a_req = 0; bus.b_req = 0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
